// File: rtl/booth_mul_seq.sv
// Operand/result sequencer for a radix-4 Booth multiplier: one operation in flight,
// valid/ready handshakes on both sides, watchdog abort if the multiplier never reports ready.
module booth_mul_seq #(
  parameter int NB      = 32,
  parameter int TIMEOUT = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [NB-1:0]   in_a,
  input  logic [NB-1:0]   in_b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [2*NB-1:0] out_product,
  output logic            out_err,
  output logic            mul_start,
  output logic [NB-1:0]   mul_a,
  output logic [NB-1:0]   mul_b,
  input  logic [2*NB-1:0] mul_product,
  input  logic            mul_ready
);

  localparam int              WD_W    = $clog2(TIMEOUT + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE,
    LAUNCH,
    WAIT,
    HOLD
  } state_t;

  state_t          state;
  logic [WD_W-1:0] wd_cnt;

  // Every output is a register written here, so no input reaches an output combinationally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the operand and result registers are reset too, because downstream
      // logic observes them directly and must see zeros after reset, not stale data.
      state       <= IDLE;
      wd_cnt      <= '0;
      in_ready    <= 1'b1;
      out_valid   <= 1'b0;
      out_product <= '0;
      out_err     <= 1'b0;
      mul_start   <= 1'b0;
      mul_a       <= '0;
      mul_b       <= '0;
    end else begin
      // NOTE: non-blocking assignments throughout, so every branch reads the
      // pre-edge value of state and counters regardless of statement order.
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            mul_a     <= in_a;
            mul_b     <= in_b;
            mul_start <= 1'b1;
            in_ready  <= 1'b0;
            state     <= LAUNCH;
          end
        end

        LAUNCH: begin
          mul_start <= 1'b0;
          wd_cnt    <= '0;
          state     <= WAIT;
        end

        WAIT: begin
          // mul_ready is only meaningful once start has cleared the multiplier's counter.
          if (mul_ready) begin
            out_product <= mul_product;
            out_err     <= 1'b0;
            out_valid   <= 1'b1;
            state       <= HOLD;
          end else if (wd_cnt == WD_LAST) begin
            out_product <= '0;
            out_err     <= 1'b1;
            out_valid   <= 1'b1;
            state       <= HOLD;
          end else begin
            wd_cnt <= wd_cnt + WD_W'(1);
          end
        end

        HOLD: begin
          if (out_valid && out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end

        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
          mul_start <= 1'b0;
        end
      endcase
    end
  end

endmodule
